// File: rtl/reg_writeback_unit.sv
// Single register-file write port shared by pipeline writeback (priority) and a
// FIFO of long-latency results, plus a per-register outstanding-write scoreboard.
module reg_writeback_unit #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wb_valid,
  input  logic [ADDR_W-1:0]                  wb_addr,
  input  logic [WORD_SIZE-1:0]               wb_data,
  input  logic                               lu_valid,
  output logic                               lu_ready,
  input  logic [ADDR_W-1:0]                  lu_addr,
  input  logic [WORD_SIZE-1:0]               lu_data,
  input  logic                               issue_valid,
  input  logic [ADDR_W-1:0]                  issue_addr,
  output logic                               issue_stall,
  output logic [(1<<ADDR_W)-1:0]             pending,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic [ADDR_W-1:0]                  write_addr,
  output logic [WORD_SIZE-1:0]               write_data,
  output logic                               reg_write_signal
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0]    fifo_addr [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [1:0]           cnt     [NREG];
  logic [1:0]           cnt_nxt [NREG];
  logic                 wr_en_q;
  logic                 push;
  logic                 pop;
  logic [ADDR_W-1:0]    head_addr;
  logic [WORD_SIZE-1:0] head_data;

  assign lu_ready   = ~reset & (count < DEPTH_C);
  assign push       = lu_valid & lu_ready;
  assign pop        = ~wb_valid & (count != '0);
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign fifo_count = count;

  // Storage needs no reset: push is already blocked while reset is high.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lu_addr;
      fifo_data[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_addr <= '0;
      write_data <= '0;
      wr_en_q    <= 1'b0;
    end else if (wb_valid) begin
      write_addr <= wb_addr;
      write_data <= wb_data;
      wr_en_q    <= 1'b1;
    end else if (pop) begin
      write_addr <= head_addr;
      write_data <= head_data;
      wr_en_q    <= 1'b1;
    end else begin
      wr_en_q    <= 1'b0;
    end
  end

  // Masking with reset keeps a write selected just before reset off the port.
  assign reg_write_signal = wr_en_q & ~reset;

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (issue_valid && (issue_addr == ADDR_W'(r)) && !(pop && (head_addr == ADDR_W'(r))))
        cnt_nxt[r] = cnt[r] + 2'd1;
      else if (pop && (head_addr == ADDR_W'(r)) && !(issue_valid && (issue_addr == ADDR_W'(r))))
        cnt_nxt[r] = cnt[r] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (reset) cnt[r] <= '0;
      else       cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      pending[r] = (cnt[r] != 2'd0);
    end
  end

  assign issue_stall = (cnt[issue_addr] == 2'd3);

endmodule
